wb_sram_slave: RTL and testbench



---
 rtl/wb_sram_slave_if.sv | 28 ++
 rtl/wb_sram_slave.sv | 143 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 classic-cycle bus bundle between the interconnect and one RAM slave.
// The signal names keep the slave-side _i/_o view, so both modports use the same names.
interface wb_sram_slave_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                  cyc_i;
   logic                  stb_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] adr_i;
   logic [DATA_WIDTH-1:0] dat_i;
   logic [SEL_WIDTH-1:0]  sel_i;
   logic [DATA_WIDTH-1:0] dat_o;
   logic                  ack_o;
   logic                  err_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      input  dat_o, ack_o, err_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
      output dat_o, ack_o, err_o
   );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic single-port RAM slave with byte lanes, fixed wait states
// and error termination for word indices beyond DEPTH.
//
//   state | meaning
//   IDLE  | waiting for cyc&stb; request fields captured on the accepting edge
//   WAIT  | counting wait states; dropping cyc aborts with no side effects
//   RESP  | one-cycle ack or err pulse; always returns to IDLE
module wb_sram_slave #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 1
) (
   input logic             clk_i,
   input logic             rst_i,
   wb_sram_slave_if.slave  bus
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int BYTE_BITS = $clog2(SEL_WIDTH);
   localparam int IDX_W     = ADDR_WIDTH - 4 - BYTE_BITS;
   localparam logic [3:0]   WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_nx;
   logic [3:0]            cnt, cnt_nx;
   logic                  latch;
   logic                  req;
   logic                  enter_resp;

   logic [IDX_W-1:0]      idx_in;
   logic                  oor_in;

   logic                  we_q;
   logic                  oor_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [SEL_WIDTH-1:0]  sel_q;

   logic                  t_we;
   logic                  t_oor;
   logic [IDX_W-1:0]      t_idx;
   logic [DATA_WIDTH-1:0] t_dat;
   logic [SEL_WIDTH-1:0]  t_sel;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Slave-select nibble and byte-offset bits carry no meaning inside this slave.
   logic unused_adr;
   assign unused_adr = ^bus.adr_i;

   assign req    = bus.cyc_i & bus.stb_i;
   assign idx_in = bus.adr_i[ADDR_WIDTH-5:BYTE_BITS];
   assign oor_in = {1'b0, idx_in} >= DEPTH_L;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      latch    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               latch = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = WS_LOAD;
               end
            end
         end
         WAIT: begin
            if (!bus.cyc_i)       state_nx = IDLE;
            else if (cnt == '0)   state_nx = RESP;
            else                  cnt_nx   = cnt - 4'd1;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // With zero wait states RESP is entered on the accepting edge, so the live bus
   // fields are used while in IDLE and the captured copies otherwise.
   always_comb begin
      t_we  = we_q;
      t_oor = oor_q;
      t_idx = idx_q;
      t_dat = dat_q;
      t_sel = sel_q;
      if (state == IDLE) begin
         t_we  = bus.we_i;
         t_oor = oor_in;
         t_idx = idx_in;
         t_dat = bus.dat_i;
         t_sel = bus.sel_i;
      end
   end

   assign enter_resp = (state_nx == RESP) & ~rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q      <= 1'b0;
         oor_q     <= 1'b0;
         idx_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         bus.ack_o <= 1'b0;
         bus.err_o <= 1'b0;
         bus.dat_o <= '0;
      end else begin
         if (latch) begin
            we_q  <= bus.we_i;
            oor_q <= oor_in;
            idx_q <= idx_in;
            dat_q <= bus.dat_i;
            sel_q <= bus.sel_i;
         end
         bus.ack_o <= enter_resp & ~t_oor;
         bus.err_o <= enter_resp & t_oor;
         if (enter_resp && !t_oor && !t_we) bus.dat_o <= mem[t_idx];
      end
   end

   always_ff @(posedge clk_i) begin
      if (enter_resp && t_we && !t_oor) begin
         for (int k = 0; k < SEL_WIDTH; k++) begin
            if (t_sel[k]) mem[t_idx][8*k +: 8] <= t_dat[8*k +: 8];
         end
      end
   end
endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (WS=1, WS=0, WS=3 with DEPTH=768) checked
// every cycle against a transaction-level model, plus literal data/latency checks.
module tb_wb_sram_slave;
   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   cyc_n = 0;
   int   checks = 0;
   int   errors = 0;

   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [15:0] adr  [3];
   logic [31:0] wdat [3];
   logic [3:0]  sel  [3];
   wire         ack  [3];
   wire         err  [3];
   wire  [31:0] rdat [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      localparam int DP = (g == 2) ? 768 : 1024;
      wb_sram_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
      assign bus.cyc_i = cyc[g];
      assign bus.stb_i = stb[g];
      assign bus.we_i  = we[g];
      assign bus.adr_i = adr[g];
      assign bus.dat_i = wdat[g];
      assign bus.sel_i = sel[g];
      assign ack[g]    = bus.ack_o;
      assign err[g]    = bus.err_o;
      assign rdat[g]   = bus.dat_o;
      wb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(DP), .WAIT_STATES(WS)) dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (bus)
      );
   end

   function automatic int ws_of(int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   function automatic int depth_of(int i);
      return (i == 2) ? 768 : 1024;
   endfunction

   // Transaction-level model: word storage plus the one pending response per slave.
   logic [31:0] mmem [int];
   int          exp_kind [3];   // 0 none, 1 ack, 2 err
   int          exp_at   [3];
   bit          exp_rd   [3];
   logic [31:0] exp_dat  [3];
   logic [31:0] model_dat[3];
   int          acc_at   [3];
   int          seen_at  [3];
   int          ack_log  [$];
   bit          ea, ee;

   task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, act, expv);
      end
   endtask

   task automatic model_req(int i, bit w, logic [15:0] a, logic [31:0] d, logic [3:0] s, int n);
      int          idx;
      int          key;
      logic [31:0] cur;
      idx = (int'(a) % 4096) / 4;
      key = i * 4096 + idx;
      cur = mmem.exists(key) ? mmem[key] : 32'h0;
      exp_at[i] = n + ws_of(i);
      exp_rd[i] = 1'b0;
      if (idx >= depth_of(i)) begin
         exp_kind[i] = 2;
      end else begin
         exp_kind[i] = 1;
         if (w) begin
            for (int k = 0; k < 4; k++) if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
            mmem[key] = cur;
         end else begin
            exp_rd[i]  = 1'b1;
            exp_dat[i] = cur;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            ea = (exp_kind[i] == 1) && (exp_at[i] == cyc_n);
            ee = (exp_kind[i] == 2) && (exp_at[i] == cyc_n);
            if (ea && exp_rd[i]) model_dat[i] = exp_dat[i];
            if (ack[i] || err[i]) seen_at[i] = cyc_n;
            if (i == 1 && ack[i]) ack_log.push_back(cyc_n);
            check($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(ea));
            check($sformatf("err[%0d]", i), 32'(err[i]), 32'(ee));
            check($sformatf("dat_o[%0d]", i), rdat[i], model_dat[i]);
         end
      end
   end

   // Entered and left at posedge+1; inputs are scrambled after acceptance to show they are ignored.
   task automatic xfer(int i, bit w, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                       bit keep, bit drop_resp);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdat[i] = d; sel[i] = s;
      seen_at[i] = -100;
      @(posedge clk); #1;
      acc_at[i] = cyc_n;
      model_req(i, w, a, d, s, cyc_n);
      we[i] = ~w; adr[i] = ~a; wdat[i] = ~d; sel[i] = ~s;
      repeat (ws_of(i)) begin @(posedge clk); #1; end
      if (drop_resp) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
      @(posedge clk); #1;
      if (!keep) begin cyc[i] = 1'b0; stb[i] = 1'b0; end
   endtask

   task automatic abort_wr(int i, logic [15:0] a, logic [31:0] d, int hold);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b1; adr[i] = a; wdat[i] = d; sel[i] = 4'hF;
      @(posedge clk); #1;
      repeat (hold) begin @(posedge clk); #1; end
      cyc[i] = 1'b0;
      repeat (ws_of(i) + 2) begin @(posedge clk); #1; end
      stb[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdat[i] = '0; sel[i] = '0;
         exp_kind[i] = 0; exp_at[i] = -100; exp_rd[i] = 1'b0; exp_dat[i] = '0;
         model_dat[i] = '0; acc_at[i] = 0; seen_at[i] = -100;
      end
      #1 rst = 1'b1;
      #3;
      for (int i = 0; i < 3; i++) begin
         check("reset_ack", 32'(ack[i]), 32'h0);
         check("reset_err", 32'(err[i]), 32'h0);
         check("reset_dat", rdat[i], 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // WS=1: write/read, latency, byte lanes, misaligned and slave-select bits ignored
      xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
      check("ws1_wr_latency", 32'(seen_at[0] - acc_at[0]), 32'd1);
      xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
      check("ws1_rd_data", rdat[0], 32'hDEADBEEF);
      xfer(0, 1'b1, 16'h0010, 32'h11223344, 4'b0101, 1'b0, 1'b0);
      xfer(0, 1'b0, 16'h0013, 32'h0, 4'hF, 1'b0, 1'b0);
      check("lane_merge", rdat[0], 32'hDE22BE44);
      xfer(0, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 16'hA010, 32'h0, 4'hF, 1'b0, 1'b0);
      check("sel0_no_change", rdat[0], 32'hDE22BE44);

      // WS=0: fill four words, then four reads with stb held high
      for (int k = 0; k < 4; k++)
         xfer(1, 1'b1, 16'(4 * k), 32'hC0DE0000 | 32'(k), 4'hF, 1'b0, 1'b0);
      ack_log.delete();
      for (int k = 0; k < 4; k++) begin
         xfer(1, 1'b0, 16'(4 * k), 32'h0, 4'hF, (k < 3), 1'b0);
         check("b2b_data", rdat[1], 32'hC0DE0000 | 32'(k));
      end
      check("b2b_count", 32'(ack_log.size()), 32'd4);
      for (int k = 1; k < 4; k++)
         check("b2b_gap", 32'(ack_log[k] - ack_log[k-1]), 32'd2);

      // WS=3, DEPTH=768: out-of-range error, last in-range word, cyc drop in RESP
      xfer(2, 1'b1, 16'h0000, 32'h0BADF00D, 4'hF, 1'b0, 1'b0);
      xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, 1'b0, 1'b0);
      check("ws3_rd_data", rdat[2], 32'h0BADF00D);
      xfer(2, 1'b1, 16'h0C00, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
      check("oor_err_latency", 32'(seen_at[2] - acc_at[2]), 32'd3);
      check("oor_dat_held", rdat[2], 32'h0BADF00D);
      xfer(2, 1'b0, 16'h0C04, 32'h0, 4'hF, 1'b0, 1'b0);
      check("oor_rd_dat_held", rdat[2], 32'h0BADF00D);
      xfer(2, 1'b1, 16'h0BFC, 32'h600DCAFE, 4'hF, 1'b0, 1'b0);
      xfer(2, 1'b0, 16'h0BFC, 32'h0, 4'hF, 1'b0, 1'b1);
      check("last_word_rd", rdat[2], 32'h600DCAFE);
      xfer(2, 1'b0, 16'h0000, 32'h0, 4'hF, 1'b0, 1'b0);
      check("word0_intact", rdat[2], 32'h0BADF00D);

      // Abort during WAIT leaves the old word
      xfer(2, 1'b1, 16'h0020, 32'h00000011, 4'hF, 1'b0, 1'b0);
      abort_wr(2, 16'h0020, 32'h00000055, 1);
      xfer(2, 1'b0, 16'h0020, 32'h0, 4'hF, 1'b0, 1'b0);
      check("abort_no_write", rdat[2], 32'h00000011);

      // Asynchronous reset between edges while a write sits in WAIT
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'h0020;
      wdat[2] = 32'h00000099; sel[2] = 4'hF;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin exp_kind[i] = 0; model_dat[i] = '0; end
      #1;
      for (int i = 0; i < 3; i++) begin
         check("async_rst_ack", 32'(ack[i]), 32'h0);
         check("async_rst_err", 32'(err[i]), 32'h0);
         check("async_rst_dat", rdat[i], 32'h0);
      end
      cyc[2] = 1'b0; stb[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xfer(2, 1'b0, 16'h0020, 32'h0, 4'hF, 1'b0, 1'b0);
      check("post_rst_no_write", rdat[2], 32'h00000011);
      xfer(0, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 1'b0);
      check("post_rst_retained", rdat[0], 32'hDE22BE44);

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
